// File: rtl/wdt_device.sv
// wdt_device: watchdog timer on the device bus (request/rvalid protocol).
// Ports: clk_i/rst_i (sync, active-high); device_* bus slave; wdt_irq_o bark, wdt_rst_req_o bite.
module wdt_device #(
    parameter int unsigned PrescaleDiv = 1,
    parameter logic [31:0] KickMagic   = 32'h5A5A_A5A5
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        device_req_i,
    input  logic [31:0] device_addr_i,
    input  logic        device_we_i,
    input  logic [3:0]  device_be_i,
    input  logic [31:0] device_wdata_i,
    output logic        device_rvalid_o,
    output logic [31:0] device_rdata_o,
    output logic        device_err_o,
    output logic        wdt_irq_o,
    output logic        wdt_rst_req_o
);

    localparam logic [15:0] PresMax = 16'(PrescaleDiv - 1);

    localparam logic [2:0] RegCtrl   = 3'd0;
    localparam logic [2:0] RegBark   = 3'd1;
    localparam logic [2:0] RegBite   = 3'd2;
    localparam logic [2:0] RegCount  = 3'd3;
    localparam logic [2:0] RegKick   = 3'd4;
    localparam logic [2:0] RegStatus = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_BITTEN
    } state_e;

    state_e      state_q;
    state_e      state_d;
    logic        ctrl_en_q;
    logic        ctrl_lock_q;
    logic [31:0] bark_q;
    logic [31:0] bite_q;
    logic [31:0] count_q;
    logic [15:0] presc_q;
    logic        barked_q;
    logic        rvalid_q;
    logic        err_q;
    logic [31:0] rdata_q;
    logic [31:0] rd_mux;

    logic [2:0]  reg_idx;
    logic        wr;
    logic        wr_cfg;
    logic        bad_addr;
    logic        kick_valid;
    logic        w1c;
    logic        run_active;
    logic        bite_hit;
    logic        bark_hit;
    logic        unused_addr;

    assign unused_addr = ^{device_addr_i[31:5], device_addr_i[1:0]};

    assign reg_idx  = device_addr_i[4:2];
    assign wr       = device_req_i & device_we_i;
    assign bad_addr = reg_idx[2] & reg_idx[1];
    // Config registers become read-only once LOCK is set.
    assign wr_cfg   = wr & ~ctrl_lock_q;

    assign kick_valid = wr && reg_idx == RegKick &&
                        device_be_i == 4'hF &&
                        device_wdata_i == KickMagic &&
                        state_q != ST_BITTEN;

    assign w1c = wr && reg_idx == RegStatus &&
                 device_be_i[0] && device_wdata_i[0];

    // A valid kick masks every compare and tick in its cycle.
    assign run_active = (state_q == ST_RUN) & ctrl_en_q;
    assign bite_hit   = run_active & ~kick_valid & (count_q >= bite_q);
    assign bark_hit   = run_active & ~kick_valid & (count_q >= bark_q);

    function automatic logic [31:0] be_merge(
        input logic [31:0] old_v,
        input logic [31:0] new_v,
        input logic [3:0]  be
    );
        logic [31:0] r;
        r = old_v;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) r[8*i +: 8] = new_v[8*i +: 8];
        end
        return r;
    endfunction

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (ctrl_en_q) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (!ctrl_en_q)    state_d = ST_IDLE;
                else if (bite_hit) state_d = ST_BITTEN;
            end
            ST_BITTEN: begin
                state_d = ST_BITTEN;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        rd_mux = '0;
        unique case (reg_idx)
            RegCtrl:   rd_mux = {30'd0, ctrl_lock_q, ctrl_en_q};
            RegBark:   rd_mux = bark_q;
            RegBite:   rd_mux = bite_q;
            RegCount:  rd_mux = count_q;
            RegStatus: rd_mux = {31'd0, barked_q};
            default:   rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ctrl_en_q   <= 1'b0;
            ctrl_lock_q <= 1'b0;
            bark_q      <= '1;
            bite_q      <= '1;
            count_q     <= '0;
            presc_q     <= '0;
            barked_q    <= 1'b0;
            rvalid_q    <= 1'b0;
            err_q       <= 1'b0;
            rdata_q     <= '0;
        end else begin
            if (wr_cfg && reg_idx == RegCtrl && device_be_i[0]) begin
                ctrl_en_q   <= device_wdata_i[0];
                ctrl_lock_q <= device_wdata_i[1];
            end
            if (wr_cfg && reg_idx == RegBark) begin
                bark_q <= be_merge(bark_q, device_wdata_i, device_be_i);
            end
            if (wr_cfg && reg_idx == RegBite) begin
                bite_q <= be_merge(bite_q, device_wdata_i, device_be_i);
            end

            // On the bite cycle the count stays at the value that bit.
            if (kick_valid) begin
                count_q <= '0;
                presc_q <= '0;
            end else if (run_active && !bite_hit) begin
                if (presc_q == PresMax) begin
                    presc_q <= '0;
                    if (count_q != '1) count_q <= count_q + 32'd1;
                end else begin
                    presc_q <= presc_q + 16'd1;
                end
            end

            if (bark_hit) begin
                barked_q <= 1'b1;
            end else if (w1c) begin
                barked_q <= 1'b0;
            end

            rvalid_q <= device_req_i;
            err_q    <= device_req_i & bad_addr;
            rdata_q  <= (device_req_i && !device_we_i && !bad_addr) ?
                        rd_mux : 32'd0;
        end
    end

    assign device_rvalid_o = rvalid_q;
    assign device_rdata_o  = rdata_q;
    assign device_err_o    = err_q;
    assign wdt_irq_o       = barked_q & ctrl_en_q;
    assign wdt_rst_req_o   = (state_q == ST_BITTEN);

endmodule

// File: tb/tb_wdt_device.sv
// tb_wdt_device: self-checking bench for wdt_device.
// Two instances share the bus: prescale 1 (dut) and prescale 3 (dut3).
module tb_wdt_device;

    localparam logic [31:0] MAGIC    = 32'h5A5A_A5A5;
    localparam logic [31:0] A_CTRL   = 32'h00;
    localparam logic [31:0] A_BARK   = 32'h04;
    localparam logic [31:0] A_BITE   = 32'h08;
    localparam logic [31:0] A_COUNT  = 32'h0C;
    localparam logic [31:0] A_KICK   = 32'h10;
    localparam logic [31:0] A_STATUS = 32'h14;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [31:0] addr = '0;
    logic [3:0]  be = '0;
    logic [31:0] wdata = '0;

    logic        rvalid, err, irq, rst_req;
    logic [31:0] rdata;
    logic        rvalid3, err3, irq3, rst_req3;
    logic [31:0] rdata3;

    int          n_chk = 0;
    int          n_fail = 0;
    int          cyc = 0;
    logic [31:0] rd3_last;

    wdt_device #(.PrescaleDiv(1)) dut (
        .clk_i(clk), .rst_i(rst),
        .device_req_i(req), .device_addr_i(addr),
        .device_we_i(we), .device_be_i(be),
        .device_wdata_i(wdata),
        .device_rvalid_o(rvalid), .device_rdata_o(rdata),
        .device_err_o(err),
        .wdt_irq_o(irq), .wdt_rst_req_o(rst_req)
    );

    wdt_device #(.PrescaleDiv(3)) dut3 (
        .clk_i(clk), .rst_i(rst),
        .device_req_i(req), .device_addr_i(addr),
        .device_we_i(we), .device_be_i(be),
        .device_wdata_i(wdata),
        .device_rvalid_o(rvalid3), .device_rdata_o(rdata3),
        .device_err_o(err3),
        .wdt_irq_o(irq3), .wdt_rst_req_o(rst_req3)
    );

    // cyc == number of rising edges seen so far
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    function automatic logic [31:0] merge(
        input logic [31:0] o, input logic [31:0] n, input logic [3:0] b
    );
        logic [31:0] r;
        r = o;
        for (int i = 0; i < 4; i++) if (b[i]) r[8*i +: 8] = n[8*i +: 8];
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // One access; returns response and the edge number that sampled req.
    task automatic bus(input logic w, input logic [31:0] a,
                       input logic [3:0] b, input logic [31:0] d,
                       output logic [31:0] rd, output logic e,
                       output int t);
        @(negedge clk);
        chk("rvalid_idle", {31'd0, rvalid}, 32'd0);
        req = 1'b1; we = w; addr = a; be = b; wdata = d;
        @(negedge clk);
        req = 1'b0; we = 1'b0; addr = '0; be = '0; wdata = '0;
        t = cyc;
        chk("rvalid_resp", {31'd0, rvalid}, 32'd1);
        rd = rdata;
        e = err;
        rd3_last = rdata3;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d,
                      output int t);
        logic [31:0] r;
        logic e;
        bus(1'b1, a, 4'hF, d, r, e, t);
        chk("wr_err", {31'd0, e}, 32'd0);
    endtask

    task automatic rd_chk(input string name, input logic [31:0] a,
                          input logic [31:0] exp);
        logic [31:0] r;
        logic e;
        int t;
        bus(1'b0, a, 4'hF, '0, r, e, t);
        chk(name, r, exp);
        chk({name, "_err"}, {31'd0, e}, 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; req = 1'b0; we = 1'b0; addr = '0; be = '0; wdata = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin : main
        vec_t        tbl[16];
        logic [31:0] r;
        logic        e;
        int          t, t_en, t_k, t_irq, t_bite, t_r, bad;
        logic        pend, rp, w;
        logic [31:0] exp_rd, m_bark, m_bite, d, hi;
        logic        exp_e;
        logic [2:0]  idx;
        logic [3:0]  b;

        tbl[0]  = '{1'b0, A_CTRL,   4'hF, 32'h0, 32'h0, 1'b0};
        tbl[1]  = '{1'b0, A_BARK,   4'hF, 32'h0, 32'hFFFF_FFFF, 1'b0};
        tbl[2]  = '{1'b0, A_BITE,   4'hF, 32'h0, 32'hFFFF_FFFF, 1'b0};
        tbl[3]  = '{1'b0, A_COUNT,  4'hF, 32'h0, 32'h0, 1'b0};
        tbl[4]  = '{1'b0, A_KICK,   4'hF, 32'h0, 32'h0, 1'b0};
        tbl[5]  = '{1'b0, A_STATUS, 4'hF, 32'h0, 32'h0, 1'b0};
        tbl[6]  = '{1'b0, 32'h18,   4'hF, 32'h0, 32'h0, 1'b1};
        tbl[7]  = '{1'b1, 32'h1C,   4'hF, 32'hDEAD_BEEF, 32'h0, 1'b1};
        tbl[8]  = '{1'b1, A_BARK,   4'h3, 32'h1234_5678, 32'h0, 1'b0};
        tbl[9]  = '{1'b0, A_BARK,   4'hF, 32'h0, 32'hFFFF_5678, 1'b0};
        tbl[10] = '{1'b1, A_BITE,   4'hC, 32'hAABB_CCDD, 32'h0, 1'b0};
        tbl[11] = '{1'b0, A_BITE,   4'hF, 32'h0, 32'hAABB_FFFF, 1'b0};
        tbl[12] = '{1'b1, A_COUNT,  4'hF, 32'h55, 32'h0, 1'b0};
        tbl[13] = '{1'b0, A_COUNT,  4'hF, 32'h0, 32'h0, 1'b0};
        tbl[14] = '{1'b1, A_KICK,   4'hF, 32'h1111_1111, 32'h0, 1'b0};
        tbl[15] = '{1'b0, 32'h1C,   4'hF, 32'h0, 32'h0, 1'b1};

        // Reset state and register-map table
        do_reset();
        chk("rst_outputs", {rvalid, err, irq, rst_req, rdata}, 36'h0);
        for (int i = 0; i < 16; i++) begin
            bus(tbl[i].we, tbl[i].addr, tbl[i].be, tbl[i].wdata, r, e, t);
            chk($sformatf("tbl%0d_rdata", i), r, tbl[i].exp_rdata);
            chk($sformatf("tbl%0d_err", i), {31'd0, e}, {31'd0, tbl[i].exp_err});
        end

        // Bark at t+12, bite at t+22, COUNT frozen at 20
        do_reset();
        wr(A_BARK, 32'd10, t);
        wr(A_BITE, 32'd20, t);
        wr(A_CTRL, 32'd1, t_en);
        t_irq = -1;
        t_bite = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (irq && t_irq < 0) t_irq = cyc;
            if (rst_req && t_bite < 0) t_bite = cyc;
        end
        chk("irq_rise_edge", t_irq, t_en + 12);
        chk("bite_rise_edge", t_bite, t_en + 22);
        bus(1'b0, A_COUNT, 4'hF, '0, r, e, t_r);
        chk("bitten_count", r, 32'd20);
        chk("presc3_count", rd3_last, (t_r - t_en - 2) / 3);
        repeat (5) @(negedge clk);
        rd_chk("bitten_count_hold", A_COUNT, 32'd20);
        rd_chk("bitten_status", A_STATUS, 32'd1);

        // Periodic valid kicks keep the count low
        do_reset();
        wr(A_BARK, 32'd10, t);
        wr(A_BITE, 32'd20, t);
        wr(A_CTRL, 32'd1, t_en);
        bad = 0;
        rp = 1'b0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (rp) begin
                chk("kick_rvalid", {31'd0, rvalid}, 32'd1);
                chk("kick_count", rdata, 32'd3);
            end
            if (irq || rst_req) bad++;
            rp = 1'b0; req = 1'b0; we = 1'b0;
            if (i % 8 == 0) begin
                req = 1'b1; we = 1'b1; addr = A_KICK; be = 4'hF; wdata = MAGIC;
            end else if (i % 8 == 4) begin
                req = 1'b1; addr = A_COUNT; be = 4'hF; rp = 1'b1;
            end
        end
        @(negedge clk);
        req = 1'b0; we = 1'b0;
        chk("kick_no_irq_rst", bad, 0);

        // Invalid kicks do not clear the count
        wr(A_KICK, MAGIC, t_k);
        bus(1'b1, A_KICK, 4'hF, 32'h1234_5678, r, e, t);
        chk("badkick_err", {31'd0, e}, 32'd0);
        bus(1'b1, A_KICK, 4'h3, MAGIC, r, e, t);
        chk("partkick_err", {31'd0, e}, 32'd0);
        bus(1'b0, A_COUNT, 4'hF, '0, r, e, t_r);
        chk("badkick_count", r, t_r - t_k - 1);

        // W1C clears BARKED; a W1C on the bark-set edge loses
        do_reset();
        wr(A_BARK, 32'd5, t);
        wr(A_CTRL, 32'd1, t_en);
        for (int i = 0; i < 20 && !irq; i++) @(negedge clk);
        chk("bark_irq_set", {31'd0, irq}, 32'd1);
        wr(A_KICK, MAGIC, t_k);
        chk("kick_keeps_barked", {31'd0, irq}, 32'd1);
        bus(1'b1, A_STATUS, 4'h1, 32'd1, r, e, t);
        chk("w1c_irq_drop", {31'd0, irq}, 32'd0);
        for (int i = 0; i < 10 && cyc < t_k + 4; i++) @(negedge clk);
        chk("pre_bark_irq", {31'd0, irq}, 32'd0);
        bus(1'b1, A_STATUS, 4'h1, 32'd1, r, e, t);
        chk("w1c_set_wins_irq", {31'd0, irq}, 32'd1);
        rd_chk("w1c_set_wins_status", A_STATUS, 32'd1);

        // LOCK blocks config writes, counting continues
        do_reset();
        wr(A_CTRL, 32'd3, t_en);
        wr(A_CTRL, 32'd0, t);
        wr(A_BARK, 32'd5, t);
        rd_chk("lock_ctrl", A_CTRL, 32'd3);
        rd_chk("lock_bark", A_BARK, 32'hFFFF_FFFF);
        bus(1'b0, A_COUNT, 4'hF, '0, r, e, t_r);
        chk("lock_count", r, t_r - t_en - 2);

        // BITE=0 bites on first RUN cycle; rst_i leaves BITTEN
        do_reset();
        wr(A_BITE, 32'd0, t);
        wr(A_CTRL, 32'd1, t_en);
        @(negedge clk);
        chk("bite0_before", {31'd0, rst_req}, 32'd0);
        @(negedge clk);
        chk("bite0_rise", {31'd0, rst_req}, 32'd1);
        req = 1'b1; we = 1'b0; addr = A_CTRL; be = 4'hF; rst = 1'b1;
        @(negedge clk);
        req = 1'b0; rst = 1'b0;
        chk("rst_drop_rvalid", {31'd0, rvalid}, 32'd0);
        chk("rst_clear_rstreq", {31'd0, rst_req}, 32'd0);
        repeat (3) @(negedge clk);
        chk("rst_stays_idle", {31'd0, rst_req}, 32'd0);
        rd_chk("rst_ctrl", A_CTRL, 32'd0);
        rd_chk("rst_bite", A_BITE, 32'hFFFF_FFFF);

        // Random back-to-back register traffic vs. register-map model
        do_reset();
        m_bark = '1;
        m_bite = '1;
        pend = 1'b0;
        exp_rd = '0;
        exp_e = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (pend) begin
                chk("rnd_rvalid", {31'd0, rvalid}, 32'd1);
                chk("rnd_rdata", rdata, exp_rd);
                chk("rnd_err", {31'd0, err}, {31'd0, exp_e});
            end else begin
                chk("rnd_rvalid_idle", {31'd0, rvalid}, 32'd0);
            end
            req = 1'b0; we = 1'b0;
            pend = 1'b0;
            if ($urandom_range(0, 3) != 0) begin
                idx = 3'($urandom_range(0, 7));
                w = 1'($urandom_range(0, 1));
                b = 4'($urandom);
                d = $urandom;
                hi = $urandom;
                if (idx == 3'd0) d[1:0] = 2'b00;
                req = 1'b1; we = w; be = b; wdata = d;
                addr = {hi[31:5], idx, hi[1:0]};
                exp_e = (idx >= 3'd6);
                exp_rd = '0;
                if (!w && !exp_e) begin
                    if (idx == 3'd1) exp_rd = m_bark;
                    if (idx == 3'd2) exp_rd = m_bite;
                end
                if (w && idx == 3'd1) m_bark = merge(m_bark, d, b);
                if (w && idx == 3'd2) m_bite = merge(m_bite, d, b);
                pend = 1'b1;
            end
        end
        @(negedge clk);
        req = 1'b0; we = 1'b0;
        if (pend) begin
            chk("rnd_rvalid", {31'd0, rvalid}, 32'd1);
            chk("rnd_rdata", rdata, exp_rd);
            chk("rnd_err", {31'd0, err}, {31'd0, exp_e});
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
